// File: rtl/wb_arbiter_2_masters_pkg.sv
// Shared Wishbone bus constants for the two-master arbiter: the grant states
// and the identity of the last master served.
package wb_arbiter_2_masters_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGntM0 = 2'd1,
    StGntM1 = 2'd2
  } grant_e;

  typedef enum logic {
    MstM0 = 1'b0,
    MstM1 = 1'b1
  } master_e;

endpackage

// File: rtl/wb_arbiter_2_masters.sv
// Two-master to one-slave Wishbone classic arbiter. A grant lasts for the whole
// CYC of the winning master; ties in IDLE are broken round-robin.
module wb_arbiter_2_masters
  import wb_arbiter_2_masters_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // master 0
  input  logic                  i_m0_we,
  input  logic                  i_m0_stb,
  input  logic                  i_m0_cyc,
  input  logic [SEL_WIDTH-1:0]  i_m0_sel,
  input  logic [DATA_WIDTH-1:0] i_m0_dat,
  input  logic [ADDR_WIDTH-1:0] i_m0_adr,
  output logic [DATA_WIDTH-1:0] o_m0_dat,
  output logic                  o_m0_ack,
  output logic                  o_m0_int,
  // master 1
  input  logic                  i_m1_we,
  input  logic                  i_m1_stb,
  input  logic                  i_m1_cyc,
  input  logic [SEL_WIDTH-1:0]  i_m1_sel,
  input  logic [DATA_WIDTH-1:0] i_m1_dat,
  input  logic [ADDR_WIDTH-1:0] i_m1_adr,
  output logic [DATA_WIDTH-1:0] o_m1_dat,
  output logic                  o_m1_ack,
  output logic                  o_m1_int,
  // slave
  output logic                  o_s_we,
  output logic                  o_s_stb,
  output logic                  o_s_cyc,
  output logic [SEL_WIDTH-1:0]  o_s_sel,
  output logic [DATA_WIDTH-1:0] o_s_dat,
  output logic [ADDR_WIDTH-1:0] o_s_adr,
  input  logic [DATA_WIDTH-1:0] i_s_dat,
  input  logic                  i_s_ack,
  input  logic                  i_s_int
);

  grant_e  grant_q, grant_d;
  master_e last_q, last_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q <= StIdle;
      last_q  <= MstM1;  // so master 0 wins the first tie
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    unique case (grant_q)
      StIdle: begin
        if (i_m0_cyc && i_m1_cyc) begin
          grant_d = (last_q == MstM1) ? StGntM0 : StGntM1;
        end else if (i_m0_cyc) begin
          grant_d = StGntM0;
        end else if (i_m1_cyc) begin
          grant_d = StGntM1;
        end
      end
      StGntM0: begin
        if (!i_m0_cyc) begin
          grant_d = StIdle;
          last_d  = MstM0;
        end
      end
      StGntM1: begin
        if (!i_m1_cyc) begin
          grant_d = StIdle;
          last_d  = MstM1;
        end
      end
      default: grant_d = StIdle;
    endcase
  end

  logic gnt_m0, gnt_m1;
  assign gnt_m0 = (grant_q == StGntM0);
  assign gnt_m1 = (grant_q == StGntM1);

  // cyc/stb follow the owner's live cyc so a release is seen by the slave at once
  assign o_s_cyc = (gnt_m0 & i_m0_cyc) | (gnt_m1 & i_m1_cyc);
  assign o_s_stb = (gnt_m0 & i_m0_cyc & i_m0_stb) | (gnt_m1 & i_m1_cyc & i_m1_stb);
  assign o_s_we  = gnt_m0 ? i_m0_we  : (gnt_m1 ? i_m1_we  : 1'b0);
  assign o_s_sel = gnt_m0 ? i_m0_sel : (gnt_m1 ? i_m1_sel : '0);
  assign o_s_dat = gnt_m0 ? i_m0_dat : (gnt_m1 ? i_m1_dat : '0);
  assign o_s_adr = gnt_m0 ? i_m0_adr : (gnt_m1 ? i_m1_adr : '0);

  assign o_m0_ack = i_s_ack & gnt_m0;
  assign o_m1_ack = i_s_ack & gnt_m1;
  assign o_m0_dat = gnt_m0 ? i_s_dat : '0;
  assign o_m1_dat = gnt_m1 ? i_s_dat : '0;

  assign o_m0_int = i_s_int;
  assign o_m1_int = i_s_int;

endmodule

// File: tb/tb_wb_arbiter_2_masters.sv
// Directed bench for the two-master Wishbone arbiter; acks are checked by a
// scoreboard monitor, grant/mux behaviour by direct probes.
module tb_wb_arbiter_2_masters;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_m0_we, i_m0_stb, i_m0_cyc;
  logic [3:0]  i_m0_sel;
  logic [31:0] i_m0_dat, i_m0_adr;
  logic [31:0] o_m0_dat;
  logic        o_m0_ack, o_m0_int;
  logic        i_m1_we, i_m1_stb, i_m1_cyc;
  logic [3:0]  i_m1_sel;
  logic [31:0] i_m1_dat, i_m1_adr;
  logic [31:0] o_m1_dat;
  logic        o_m1_ack, o_m1_int;
  logic        o_s_we, o_s_stb, o_s_cyc;
  logic [3:0]  o_s_sel;
  logic [31:0] o_s_dat, o_s_adr;
  logic [31:0] i_s_dat;
  logic        i_s_ack, i_s_int;

  wb_arbiter_2_masters #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .SEL_WIDTH (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_m0_we (i_m0_we),
    .i_m0_stb(i_m0_stb),
    .i_m0_cyc(i_m0_cyc),
    .i_m0_sel(i_m0_sel),
    .i_m0_dat(i_m0_dat),
    .i_m0_adr(i_m0_adr),
    .o_m0_dat(o_m0_dat),
    .o_m0_ack(o_m0_ack),
    .o_m0_int(o_m0_int),
    .i_m1_we (i_m1_we),
    .i_m1_stb(i_m1_stb),
    .i_m1_cyc(i_m1_cyc),
    .i_m1_sel(i_m1_sel),
    .i_m1_dat(i_m1_dat),
    .i_m1_adr(i_m1_adr),
    .o_m1_dat(o_m1_dat),
    .o_m1_ack(o_m1_ack),
    .o_m1_int(o_m1_int),
    .o_s_we  (o_s_we),
    .o_s_stb (o_s_stb),
    .o_s_cyc (o_s_cyc),
    .o_s_sel (o_s_sel),
    .o_s_dat (o_s_dat),
    .o_s_adr (o_s_adr),
    .i_s_dat (i_s_dat),
    .i_s_ack (i_s_ack),
    .i_s_int (i_s_int)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        m1;
    logic [31:0] dat;
    logic [31:0] adr;
    logic        we;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ack(input logic m1, input logic [31:0] dat, input logic [31:0] adr,
                          input logic we);
    exp_t e;
    e.m1 = m1; e.dat = dat; e.adr = adr; e.we = we;
    sb.push_back(e);
    i_s_dat = dat;
    i_s_ack = 1'b1;
  endtask

  // Monitor: every ack presented to a master consumes one scoreboard entry
  always @(negedge clk) begin
    if (o_m0_ack || o_m1_ack) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_ack: got m0_ack=%0b m1_ack=%0b expected none",
                 o_m0_ack, o_m1_ack);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_m0_ack", {31'd0, o_m0_ack}, {31'd0, ~e.m1});
        check("sb_m1_ack", {31'd0, o_m1_ack}, {31'd0, e.m1});
        check("sb_m0_dat", o_m0_dat, e.m1 ? 32'd0 : e.dat);
        check("sb_m1_dat", o_m1_dat, e.m1 ? e.dat : 32'd0);
        check("sb_s_adr", o_s_adr, e.adr);
        check("sb_s_we", {31'd0, o_s_we}, {31'd0, e.we});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    {i_m0_we, i_m0_stb, i_m0_cyc, i_m1_we, i_m1_stb, i_m1_cyc} = '0;
    {i_m0_sel, i_m1_sel} = '0;
    {i_m0_dat, i_m0_adr, i_m1_dat, i_m1_adr} = '0;
    i_s_int = 1'b0;
    rst     = 1'b0;
    // Requests and slave response during reset must not leak through
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_adr = 32'h55;
    i_s_ack  = 1'b1; i_s_dat = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    check("rst_s_cyc", {31'd0, o_s_cyc}, 32'd0);
    check("rst_s_stb", {31'd0, o_s_stb}, 32'd0);
    check("rst_s_adr", o_s_adr, 32'd0);
    check("rst_m0_ack", {31'd0, o_m0_ack}, 32'd0);
    check("rst_m0_dat", o_m0_dat, 32'd0);
    check("rst_m1_dat", o_m1_dat, 32'd0);
    tick();
    i_m0_cyc = 1'b0; i_m0_stb = 1'b0; i_m0_adr = '0; i_s_ack = 1'b0; i_s_dat = '0;
    tick();
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("idle_s_cyc", {31'd0, o_s_cyc}, 32'd0);

    // M0 write
    tick();
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_we = 1'b1;
    i_m0_adr = 32'h100; i_m0_dat = 32'hDEAD_BEEF; i_m0_sel = 4'hF;
    @(negedge clk);
    check("m0w_latency", {31'd0, o_s_cyc}, 32'd0);
    tick();
    @(negedge clk);
    check("m0w_s_adr", o_s_adr, 32'h100);
    check("m0w_s_dat", o_s_dat, 32'hDEAD_BEEF);
    check("m0w_s_sel", {28'd0, o_s_sel}, 32'hF);
    check("m0w_s_we", {31'd0, o_s_we}, 32'd1);
    check("m0w_s_cyc", {31'd0, o_s_cyc}, 32'd1);
    check("m0w_s_stb", {31'd0, o_s_stb}, 32'd1);
    tick();
    push_ack(1'b0, 32'hCAFE_0001, 32'h100, 1'b1);
    tick();
    i_s_ack = 1'b0; i_m0_cyc = 1'b0; i_m0_stb = 1'b0; i_m0_we = 1'b0;
    @(negedge clk);
    check("m0w_cyc_drop", {31'd0, o_s_cyc}, 32'd0);
    check("m0w_stb_drop", {31'd0, o_s_stb}, 32'd0);

    // M1 read
    tick();
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_we = 1'b0; i_m1_adr = 32'h200;
    tick();
    push_ack(1'b1, 32'h1234_5678, 32'h200, 1'b0);
    tick();
    i_s_ack = 1'b0; i_m1_cyc = 1'b0; i_m1_stb = 1'b0;
    tick();

    // Simultaneous request after reset: M0 first, M1 after one idle cycle
    rst = 1'b0;
    tick();
    rst = 1'b1;
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_adr = 32'hA00;
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_adr = 32'hB00;
    tick();
    @(negedge clk);
    check("both_first_m0", o_s_adr, 32'hA00);
    tick();
    push_ack(1'b0, 32'h11, 32'hA00, 1'b0);
    tick();
    i_s_ack = 1'b0; i_m0_cyc = 1'b0; i_m0_stb = 1'b0;
    @(negedge clk);
    check("handover_drop", {31'd0, o_s_cyc}, 32'd0);
    tick();
    @(negedge clk);
    check("handover_idle", {31'd0, o_s_cyc}, 32'd0);
    tick();
    @(negedge clk);
    check("handover_m1_cyc", {31'd0, o_s_cyc}, 32'd1);
    check("handover_m1_adr", o_s_adr, 32'hB00);
    tick();
    push_ack(1'b1, 32'h22, 32'hB00, 1'b0);
    tick();
    i_s_ack = 1'b0; i_m1_cyc = 1'b0; i_m1_stb = 1'b0;
    tick();

    // M0 alone, then a tie must go to M1
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_adr = 32'hC00;
    tick();
    push_ack(1'b0, 32'h33, 32'hC00, 1'b0);
    tick();
    i_s_ack = 1'b0; i_m0_cyc = 1'b0; i_m0_stb = 1'b0;
    tick();
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_adr = 32'hD00;
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_adr = 32'hE00;
    tick();
    @(negedge clk);
    check("rr_m1_wins", o_s_adr, 32'hE00);
    tick();
    push_ack(1'b1, 32'h44, 32'hE00, 1'b0);
    tick();
    i_s_ack = 1'b0; i_m1_cyc = 1'b0; i_m1_stb = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rr_m0_next", o_s_adr, 32'hD00);
    tick();
    i_m0_cyc = 1'b0; i_m0_stb = 1'b0;
    tick(); tick();

    // Hold: M1 requests during a 4-beat M0 burst
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_adr = 32'h300;
    tick();
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_adr = 32'h400;
    for (int i = 0; i < 4; i++) begin
      i_m0_adr = 32'h300 + 32'(4 * i);
      push_ack(1'b0, 32'hA0 + 32'(i), i_m0_adr, 1'b0);
      tick();
      i_s_ack = 1'b0;
      tick();
    end
    i_m0_cyc = 1'b0; i_m0_stb = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("hold_m1_after", o_s_adr, 32'h400);
    tick();
    i_m1_cyc = 1'b0; i_m1_stb = 1'b0;
    tick(); tick();

    // Interrupt broadcast
    i_s_int = 1'b1;
    @(negedge clk);
    check("int_m0_hi", {31'd0, o_m0_int}, 32'd1);
    check("int_m1_hi", {31'd0, o_m1_int}, 32'd1);
    tick();
    i_s_int = 1'b0;
    @(negedge clk);
    check("int_m0_lo", {31'd0, o_m0_int}, 32'd0);

    // Reset abort during a granted cycle
    tick();
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_adr = 32'h500;
    tick();
    @(negedge clk);
    check("abort_pre_cyc", {31'd0, o_s_cyc}, 32'd1);
    tick();
    rst = 1'b0; i_s_ack = 1'b1; i_s_dat = 32'h5555_AAAA;
    #1;
    check("abort_s_cyc", {31'd0, o_s_cyc}, 32'd0);
    check("abort_s_stb", {31'd0, o_s_stb}, 32'd0);
    check("abort_m0_ack", {31'd0, o_m0_ack}, 32'd0);
    check("abort_m0_dat", o_m0_dat, 32'd0);
    tick();
    i_s_ack = 1'b0; i_m0_cyc = 1'b0; i_m0_stb = 1'b0;
    tick();
    rst = 1'b1;
    repeat (3) tick();
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
